// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch definitions: state encoding, PC increment and default reset PC.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FULL = 2'd3
    } fetch_state_e;

    localparam int unsigned PC_INCR          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_watchdog.sv
// Fetch watchdog: counts cycles spent in one REQ/WAIT stay and raises a sticky
// timeout flag when the stay reaches MAX_WAIT cycles.
module fetch_watchdog #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic restart,
    output logic hit,
    output logic timeout_o
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt;

    // hit fires on the MAX_WAIT-th cycle of the stay so the FSM leaves on that edge
    assign hit = active && (cnt == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (!active || restart) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (hit) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: next-PC selection, single-outstanding imem
// requests and a one-entry instruction buffer. Optional watchdog: FETCH_TIMEOUT_EN.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned                REG_DATA_WIDTH = 32,
    parameter logic [REG_DATA_WIDTH-1:0]  RESET_PC       = REG_DATA_WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned                MAX_WAIT       = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [REG_DATA_WIDTH-1:0] new_pc_o,
    output logic                      imem_req_o,
    output logic [REG_DATA_WIDTH-1:0] imem_addr_o,
    input  logic                      imem_gnt_i,
    input  logic                      imem_rvalid_i,
    input  logic [31:0]               imem_rdata_i,
    output logic                      instr_valid_o,
    output logic [31:0]               instr_o,
    output logic [REG_DATA_WIDTH-1:0] instr_pc_o,
    input  logic                      instr_ready_i,
    input  logic                      redirect_i,
    input  logic [REG_DATA_WIDTH-1:0] redirect_pc_i,
    input  logic                      halt_i,
    output logic                      timeout_o
);

    localparam int unsigned W = REG_DATA_WIDTH;

    fetch_state_e  state, state_next;
    logic [W-1:0]  fetch_pc, fetch_pc_next;
    logic [W-1:0]  redirect_pc;
    logic          kill, kill_next;
    logic          capture;
    logic          wd_hit;
    logic          timed_out;
    logic          unused_bits;

    assign redirect_pc = {redirect_pc_i[W-1:2], 2'b00};

`ifdef FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    ((state == ST_REQ) || (state == ST_WAIT)),
        .restart   (state_next != state),
        .hit       (wd_hit),
        .timeout_o (timed_out)
    );
    assign unused_bits = ^redirect_pc_i[1:0];
`else
    assign wd_hit      = 1'b0;
    assign timed_out   = 1'b0;
    assign unused_bits = ^{redirect_pc_i[1:0], MAX_WAIT};
`endif

    assign timeout_o     = timed_out;
    assign new_pc_o      = fetch_pc_next;
    assign imem_addr_o   = fetch_pc;
    assign instr_valid_o = (state == ST_FULL);

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        kill_next     = kill;
        capture       = 1'b0;
        imem_req_o    = (state == ST_REQ);

        case (state)
            ST_IDLE: begin
                if (redirect_i) fetch_pc_next = redirect_pc;
                if (!halt_i && !timed_out) state_next = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_i) fetch_pc_next = redirect_pc;
                // a grant coinciding with a redirect fetched the stale address
                if (imem_gnt_i) begin
                    state_next = ST_WAIT;
                    kill_next  = redirect_i;
                end
            end
            ST_WAIT: begin
                if (redirect_i) fetch_pc_next = redirect_pc;
                if (imem_rvalid_i) begin
                    kill_next = 1'b0;
                    if (kill || redirect_i) begin
                        state_next = halt_i ? ST_IDLE : ST_REQ;
                    end else begin
                        capture       = 1'b1;
                        fetch_pc_next = fetch_pc + W'(PC_INCR);
                        state_next    = ST_FULL;
                    end
                end else if (redirect_i) begin
                    kill_next = 1'b1;
                end
            end
            ST_FULL: begin
                if (redirect_i) begin
                    fetch_pc_next = redirect_pc;
                    state_next    = halt_i ? ST_IDLE : ST_REQ;
                end else if (instr_ready_i) begin
                    state_next = halt_i ? ST_IDLE : ST_REQ;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (wd_hit) begin
            state_next = ST_IDLE;
            kill_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            fetch_pc   <= RESET_PC;
            kill       <= 1'b0;
            instr_o    <= '0;
            instr_pc_o <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            kill     <= kill_next;
            if (capture) begin
                instr_o    <= imem_rdata_i;
                instr_pc_o <= fetch_pc;
            end
        end
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controls instruction fetch for the RV32I core. It owns the next-PC decision driven into the program counter register, issues one-at-a-time requests to instruction memory, and holds the returned instruction in a one-entry buffer until decode accepts it. It sits between the program counter register, the instruction memory port and decode. Redirects (branch, jump, trap) and halt arrive from execute/control.

## Interface
- REG_DATA_WIDTH, 32, PC and address width
- RESET_PC, 0, fetch address after reset
- MAX_WAIT, 15, watchdog limit in cycles (used only with FETCH_TIMEOUT_EN)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- new_pc_o  out  W  value the PC register loads on the next edge
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  W  fetch address, bits [1:0] always 0
- imem_gnt_i  in  1  memory accepted the request this cycle
- imem_rvalid_i  in  1  read data valid, at least 1 cycle after gnt
- imem_rdata_i  in  32  instruction word
- instr_valid_o  out  1  buffered instruction valid to decode
- instr_o  out  32  buffered instruction
- instr_pc_o  out  W  PC of instr_o
- instr_ready_i  in  1  decode accepts instr_o this cycle
- redirect_i  in  1  control-flow change, single-cycle pulse
- redirect_pc_i  in  W  redirect target; bits [1:0] are masked to 0
- halt_i  in  1  level signal: stop issuing new fetches
- timeout_o  out  1  sticky watchdog flag (only with FETCH_TIMEOUT_EN)

## Operation
- Internal fetch_pc register.
  - new_pc_o is the combinational next value of fetch_pc.
  - imem_addr_o equals fetch_pc.
- States and transitions:
  - IDLE -> REQ when !halt_i.
  - REQ: imem_req_o=1. REQ -> WAIT on gnt.
  - WAIT -> FULL on rvalid, capturing rdata and fetch_pc into the buffer; fetch_pc advances by 4.
  - FULL -> REQ on instr_ready_i, or -> IDLE if halt_i.
- Only one request is outstanding at a time. A new request never issues before rvalid of the previous one.
- Redirect rules:
  - IDLE or REQ: fetch_pc <= redirect_pc next edge. In REQ the address may change before gnt; a gnt in the same cycle as the redirect fetches the old address, which is then killed as in WAIT.
  - WAIT: set kill flag; fetch_pc <= redirect_pc. The returning data is discarded, then -> REQ at the new PC.
  - FULL: drop the buffer (instr_valid_o=0 next cycle) and go -> REQ.
  - Redirect in the same cycle as rvalid or instr_ready_i: the redirect wins and the data is discarded.
- halt_i:
  - In REQ, the request stays until gnt.
  - An outstanding fetch completes and is buffered normally.
  - No new request issues while halt_i=1.
- Arithmetic: fetch_pc+4 wraps modulo 2^W; 0xFFFFFFFC+4 gives 0.

## Timing
- Reset values: fetch_pc=RESET_PC, state IDLE, new_pc_o=RESET_PC, imem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, kill=0, timeout_o=0.
- Reset is asynchronous. Asserting it mid-fetch drops all state immediately; a late rvalid after reset release while in IDLE/REQ is ignored.
- First imem_req_o is high 1 cycle after rst_n deasserts (halt_i=0).
- instr_valid_o rises on the edge after rvalid: registered, with 1-cycle latency.
- Best-case throughput is 1 instruction per 3 cycles: REQ+gnt, WAIT+rvalid, FULL+ready.
- instr_o and instr_pc_o hold stable while instr_valid_o=1 and !instr_ready_i.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A counter runs in REQ/WAIT and clears on any state change.
  - Reaching MAX_WAIT sets timeout_o, which stays set until reset; the state machine forces -> IDLE and clears kill.
- Undefined: no counter, and timeout_o is tied 0.

## Structure
- Shared core package holds:
  - the state encoding (IDLE, REQ, WAIT, FULL; 2 bits);
  - the PC increment constant 4;
  - the default RESET_PC.
- One sub-module, fetch_watchdog (counter plus sticky flag), instantiated only under FETCH_TIMEOUT_EN.
- The program counter register stays external and is fed from new_pc_o.

## Test plan
- Reset release, gnt same cycle, rvalid 1 cycle later, ready=1 -> fetches at 0x0, 0x4, 0x8; instr_pc_o matches each fetch address; one instruction per 3 cycles.
- redirect_i to 0x100 while in WAIT -> the returning 0x8 word is never shown; next imem_addr_o=0x100.
- ready=0 for 5 cycles in FULL -> instr_o/instr_pc_o stable, imem_req_o=0; ready=1 -> next request at pc+4.
- redirect_pc_i=0xFFFFFFFC, then sequential fetch -> next address 0x00000000; redirect_pc_i=0x103 -> address 0x100.
- halt_i raised in WAIT -> the instruction is buffered and delivered, then the block stays IDLE with no request; halt_i low -> request resumes 1 cycle later.
- FETCH_TIMEOUT_EN, MAX_WAIT=15, gnt held 0 -> timeout_o=1 after 15 REQ cycles, state IDLE; rst_n pulse clears it.
